// File: rtl/aes_pipelined_stream_ctrl_pkg.sv
// Shared FSM encodings and sticky error bit positions for the AES streaming controller.
package aes_pipelined_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FIFO_ERR_PT_OVF   = 0;
    localparam int FIFO_ERR_PT_EMPTY = 1;
    localparam int FIFO_ERR_CT_OVF   = 2;
    localparam int FIFO_ERR_CT_UDF   = 3;

endpackage

// File: rtl/aes_pipelined_stream_ctrl_if.sv
// Register-block / AES-core facing signal bundle of the streaming controller.
interface aes_pipelined_stream_ctrl_if #(
    parameter int pPT_WIDTH = 128,
    parameter int pCT_WIDTH = 128
);
    logic                 I_pt_write;
    logic [pPT_WIDTH-1:0] I_textin;
    logic                 I_start;
    logic [pPT_WIDTH-1:0] O_pt_data;
    logic                 O_pt_valid;
    logic [pCT_WIDTH-1:0] I_ct_data;
    logic                 I_ct_valid;
    logic                 I_ct_read;
    logic [pCT_WIDTH-1:0] O_cipherout;
    logic                 O_fifo_out_empty;
    logic                 O_busy;
    logic                 O_trigger;
    logic                 I_clear_fifo_errors;
    logic [3:0]           O_fifo_errors;

    modport slave (
        input  I_pt_write, I_textin, I_start, I_ct_data, I_ct_valid, I_ct_read,
               I_clear_fifo_errors,
        output O_pt_data, O_pt_valid, O_cipherout, O_fifo_out_empty, O_busy,
               O_trigger, O_fifo_errors
    );

    modport master (
        output I_pt_write, I_textin, I_start, I_ct_data, I_ct_valid, I_ct_read,
               I_clear_fifo_errors,
        input  O_pt_data, O_pt_valid, O_cipherout, O_fifo_out_empty, O_busy,
               O_trigger, O_fifo_errors
    );
endinterface

// File: rtl/aes_pipelined_stream_ctrl_fifo.sv
// Single-clock first-word fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module aes_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 512
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/aes_pipelined_stream_ctrl.sv
// Streams buffered plaintexts into a pipelined AES core and collects ciphertexts,
// never issuing more than the ciphertext FIFO can absorb.
module aes_pipelined_stream_ctrl
    import aes_pipelined_stream_ctrl_pkg::*;
#(
    parameter int pPT_WIDTH   = 128,
    parameter int pCT_WIDTH   = 128,
    parameter int pFIFO_DEPTH = 512
) (
    input  logic                        crypto_clk,
    input  logic                        reset_i,
    aes_pipelined_stream_ctrl_if.slave  bus
);
    localparam int CW = $clog2(pFIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(pFIFO_DEPTH);

    state_e               state_q, state_d;
    logic [CW-1:0]        remaining_q, remaining_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [pPT_WIDTH-1:0] pt_data_q;
    logic                 pt_valid_q;
    logic                 trigger_q, trigger_d;
    logic [3:0]           err_q, err_ev;

    logic [pPT_WIDTH-1:0] pt_dout;
    logic [pCT_WIDTH-1:0] ct_dout;
    logic [CW-1:0]        pt_count, ct_count;
    logic                 pt_empty, pt_full, ct_empty, ct_full;
    logic                 issue, ct_ret;
    logic [CW:0]          occupancy;

    aes_sync_fifo #(.WIDTH(pPT_WIDTH), .DEPTH(pFIFO_DEPTH)) u_pt_fifo (
        .clk(crypto_clk), .srst(reset_i),
        .wr_en(bus.I_pt_write), .din(bus.I_textin), .rd_en(issue),
        .dout(pt_dout), .empty(pt_empty), .full(pt_full), .count(pt_count)
    );

    aes_sync_fifo #(.WIDTH(pCT_WIDTH), .DEPTH(pFIFO_DEPTH)) u_ct_fifo (
        .clk(crypto_clk), .srst(reset_i),
        .wr_en(bus.I_ct_valid), .din(bus.I_ct_data), .rd_en(bus.I_ct_read),
        .dout(ct_dout), .empty(ct_empty), .full(ct_full), .count(ct_count)
    );

    // Results already in the core count against ct FIFO space so a return can never be dropped.
    assign occupancy  = {1'b0, ct_count} + {1'b0, inflight_q};
    assign issue      = (state_q == ST_RUN) && (remaining_q != '0) &&
                        (occupancy < DEPTH_W) && !pt_empty;
    assign ct_ret     = bus.I_ct_valid && (inflight_q != '0);
    assign inflight_d = inflight_q + CW'(issue) - CW'(ct_ret);
    assign trigger_d  = (trigger_q || issue) && !((state_q == ST_DRAIN) && (inflight_d == '0));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        err_ev      = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.I_start) begin
                    if (pt_count != '0) begin
                        remaining_d = pt_count;
                        state_d     = ST_RUN;
                    end else begin
                        err_ev[FIFO_ERR_PT_EMPTY] = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CW'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight_d == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        err_ev[FIFO_ERR_PT_OVF] = bus.I_pt_write && pt_full && !issue;
        err_ev[FIFO_ERR_CT_OVF] = bus.I_ct_valid && ct_full && !bus.I_ct_read;
        err_ev[FIFO_ERR_CT_UDF] = bus.I_ct_read && ct_empty;
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            inflight_q  <= '0;
            pt_data_q   <= '0;
            pt_valid_q  <= 1'b0;
            trigger_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            pt_valid_q  <= issue;
            trigger_q   <= trigger_d;
            // New events win over a simultaneous clear.
            err_q       <= (err_q & {4{~bus.I_clear_fifo_errors}}) | err_ev;
            if (issue) pt_data_q <= pt_dout;
        end
    end

    assign bus.O_pt_data        = pt_data_q;
    assign bus.O_pt_valid       = pt_valid_q;
    assign bus.O_cipherout      = ct_dout;
    assign bus.O_fifo_out_empty = ct_empty;
    assign bus.O_busy           = (state_q != ST_IDLE);
    assign bus.O_trigger        = trigger_q;
    assign bus.O_fifo_errors    = err_q;
endmodule

// File: tb/tb_aes_pipelined_stream_ctrl.sv
// Directed bench for the AES streaming controller with a 10-cycle XOR core model.
module tb_aes_pipelined_stream_ctrl;
    localparam logic [127:0] CT_KEY = 128'hC0DE;

    logic clk;
    logic reset_i;
    int   checks = 0;
    int   errors = 0;

    aes_pipelined_stream_ctrl_if #(.pPT_WIDTH(128), .pCT_WIDTH(128)) bus ();

    aes_pipelined_stream_ctrl #(.pPT_WIDTH(128), .pCT_WIDTH(128), .pFIFO_DEPTH(512)) dut (
        .crypto_clk(clk),
        .reset_i(reset_i),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]   pipe_v;
    logic [127:0] pipe_d [10];
    logic         inj_v;
    logic [127:0] inj_d;

    always @(posedge clk) begin
        if (reset_i) begin
            pipe_v <= '0;
        end else begin
            pipe_v    <= {pipe_v[8:0], bus.O_pt_valid};
            pipe_d[0] <= bus.O_pt_data ^ CT_KEY;
            for (int k = 1; k < 10; k++) pipe_d[k] <= pipe_d[k-1];
        end
    end

    assign bus.I_ct_valid = pipe_v[9] | inj_v;
    assign bus.I_ct_data  = inj_v ? inj_d : pipe_d[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [127:0] d);
        bus.I_pt_write = 1'b1;
        bus.I_textin   = d;
        tick();
        bus.I_pt_write = 1'b0;
    endtask

    task automatic pulse_start();
        bus.I_start = 1'b1;
        tick();
        bus.I_start = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [127:0] exp);
        check(tag, bus.O_cipherout, exp);
        bus.I_ct_read = 1'b1;
        tick();
        bus.I_ct_read = 1'b0;
    endtask

    task automatic collect(input int cycles, output int n, output logic [127:0] first,
                           output logic [127:0] last);
        n     = 0;
        first = '0;
        last  = '0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.O_pt_valid) begin
                if (n == 0) first = bus.O_pt_data;
                last = bus.O_pt_data;
                n++;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    int           n;
    logic [127:0] first, last;

    initial begin
        reset_i                 = 1'b1;
        inj_v                   = 1'b0;
        inj_d                   = '0;
        bus.I_pt_write          = 1'b0;
        bus.I_textin            = '0;
        bus.I_start             = 1'b0;
        bus.I_ct_read           = 1'b0;
        bus.I_clear_fifo_errors = 1'b0;
        apply_reset();

        check("rst_pt_valid", 128'(bus.O_pt_valid), 0);
        check("rst_pt_data", bus.O_pt_data, 0);
        check("rst_busy", 128'(bus.O_busy), 0);
        check("rst_trigger", 128'(bus.O_trigger), 0);
        check("rst_errors", 128'(bus.O_fifo_errors), 0);
        check("rst_empty", 128'(bus.O_fifo_out_empty), 1);

        // Three-entry burst, start at cycle 0.
        push(128'h1);
        push(128'h2);
        push(128'h3);
        pulse_start();
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("b3_valid_c%0d", c), 128'(bus.O_pt_valid), 128'(c >= 2 && c <= 4));
            if (c >= 2 && c <= 4) check($sformatf("b3_data_c%0d", c), bus.O_pt_data, 128'(c - 1));
            check($sformatf("b3_trig_c%0d", c), 128'(bus.O_trigger), 128'(c >= 2 && c <= 14));
            check($sformatf("b3_busy_c%0d", c), 128'(bus.O_busy), 128'(c <= 14));
            tick();
        end
        pop_check("b3_ct0", 128'hC0DF);
        pop_check("b3_ct1", 128'hC0DC);
        pop_check("b3_ct2", 128'hC0DD);
        check("b3_empty_after", 128'(bus.O_fifo_out_empty), 1);
        check("b3_errors", 128'(bus.O_fifo_errors), 0);

        // Start on empty pt FIFO, with a simultaneous clear that must not win.
        bus.I_clear_fifo_errors = 1'b1;
        pulse_start();
        bus.I_clear_fifo_errors = 1'b0;
        check("empty_start_err", 128'(bus.O_fifo_errors), 128'h2);
        check("empty_start_busy", 128'(bus.O_busy), 0);
        bus.I_clear_fifo_errors = 1'b1;
        tick();
        bus.I_clear_fifo_errors = 1'b0;
        check("clear_err", 128'(bus.O_fifo_errors), 0);

        // Overfill pt FIFO, then underflow the ct FIFO.
        for (int i = 0; i < 513; i++) push(128'(i));
        check("pt_ovf_err", 128'(bus.O_fifo_errors), 128'h1);
        bus.I_ct_read = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.I_ct_read = 1'b0;
        check("ct_udf_err", 128'(bus.O_fifo_errors), 128'h9);
        check("ct_udf_empty", 128'(bus.O_fifo_out_empty), 1);
        bus.I_clear_fifo_errors = 1'b1;
        tick();
        bus.I_clear_fifo_errors = 1'b0;
        pulse_start();
        collect(560, n, first, last);
        check("full_burst_count", 128'(n), 512);
        check("full_burst_first", first, 0);
        check("full_burst_last", last, 128'h1FF);
        check("full_burst_idle", 128'(bus.O_busy), 0);
        pop_check("full_ct0", 128'hC0DE);
        pop_check("full_ct1", 128'hC0DF);

        // 510 entries held: a 4-entry burst may only issue 2 until space is freed.
        push(128'h10);
        push(128'h11);
        push(128'h12);
        push(128'h13);
        pulse_start();
        collect(30, n, first, last);
        check("bp_first_count", 128'(n), 2);
        check("bp_first_data", last, 128'h11);
        check("bp_busy_held", 128'(bus.O_busy), 1);
        pop_check("bp_pop0", 128'hC0DC);
        pop_check("bp_pop1", 128'hC0DD);
        collect(30, n, first, last);
        check("bp_rest_count", 128'(n), 2);
        check("bp_rest_first", first, 128'h12);
        check("bp_rest_last", last, 128'h13);
        check("bp_idle", 128'(bus.O_busy), 0);
        check("bp_no_ct_ovf", 128'(bus.O_fifo_errors), 0);

        apply_reset();
        check("rst2_empty", 128'(bus.O_fifo_out_empty), 1);

        // Writes during a 2-entry burst wait for the next start.
        push(128'h21);
        push(128'h22);
        bus.I_start    = 1'b1;
        tick();
        bus.I_start    = 1'b0;
        bus.I_pt_write = 1'b1;
        bus.I_textin   = 128'h23;
        tick();
        bus.I_textin   = 128'h24;
        check("frz_v0", 128'(bus.O_pt_valid), 1);
        check("frz_d0", bus.O_pt_data, 128'h21);
        tick();
        bus.I_pt_write = 1'b0;
        check("frz_v1", 128'(bus.O_pt_valid), 1);
        check("frz_d1", bus.O_pt_data, 128'h22);
        tick();
        collect(20, n, first, last);
        check("frz_extra", 128'(n), 0);
        check("frz_idle", 128'(bus.O_busy), 0);
        pulse_start();
        collect(20, n, first, last);
        check("frz2_count", 128'(n), 2);
        check("frz2_first", first, 128'h23);
        check("frz2_last", last, 128'h24);

        // Reset with five results in flight, plus a late return during the reset cycle.
        for (int i = 0; i < 8; i++) push(128'h40 + 128'(i));
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy", 128'(bus.O_busy), 1);
        check("mid_trigger", 128'(bus.O_trigger), 1);
        reset_i = 1'b1;
        inj_v   = 1'b1;
        inj_d   = 128'hDEAD;
        tick();
        reset_i = 1'b0;
        inj_v   = 1'b0;
        check("mid_rst_valid", 128'(bus.O_pt_valid), 0);
        check("mid_rst_data", bus.O_pt_data, 0);
        check("mid_rst_busy", 128'(bus.O_busy), 0);
        check("mid_rst_trigger", 128'(bus.O_trigger), 0);
        check("mid_rst_errors", 128'(bus.O_fifo_errors), 0);
        check("mid_rst_empty", 128'(bus.O_fifo_out_empty), 1);
        for (int i = 0; i < 15; i++) tick();
        check("mid_rst_empty_late", 128'(bus.O_fifo_out_empty), 1);
        pulse_start();
        check("mid_rst_pt_discarded", 128'(bus.O_fifo_errors), 128'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
